// File: rtl/cpu_dbg_pkg.sv
// -----------------------------------------------------------------------------
// cpu_dbg_pkg
// Shared definitions for the CPU debug / run-control blocks.
//   - Default register-file geometry, shared with the cpu register file.
//   - Run-monitor state encoding.
//   - A small helper that says when a new run may be started.
// -----------------------------------------------------------------------------
package cpu_dbg_pkg;

  // Register-file geometry shared with the core.
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 4;

  // Default width of the run-length limit and cycle counter.
  localparam int DEF_CYCLE_W = 16;

  // Run-control state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for the first start
    ST_RUN  = 2'd1,  // core enabled, counting cycles
    ST_DUMP = 2'd2,  // core frozen, streaming registers out
    ST_DONE = 2'd3   // run and dump complete, results held
  } run_state_e;

  // A start request is honoured only while no run or dump is in progress.
  function automatic logic start_allowed(input run_state_e s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction

endpackage : cpu_dbg_pkg

// File: rtl/cpu_run_monitor_if.sv
// -----------------------------------------------------------------------------
// cpu_run_monitor_if
// Debug bus between the run monitor, the core's register file and the dump
// consumer.
//   rf_raddr   : debug read address into the register file
//   rf_rdata   : combinational read data for rf_raddr
//   dump_valid : dump word available
//   dump_ready : consumer accepts the word
//   dump_idx   : register index of dump_data
//   dump_data  : register contents
// Modports:
//   master : the run monitor (drives the read address and the dump channel)
//   slave  : register file + dump consumer side
// -----------------------------------------------------------------------------
interface cpu_run_monitor_if
  import cpu_dbg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_idx;
  logic [DATA_W-1:0] dump_data;

  modport master (
    output rf_raddr,
    input  rf_rdata,
    output dump_valid,
    input  dump_ready,
    output dump_idx,
    output dump_data
  );

  modport slave (
    input  rf_raddr,
    output rf_rdata,
    input  dump_valid,
    output dump_ready,
    input  dump_idx,
    input  dump_data
  );

endinterface : cpu_run_monitor_if

// File: rtl/cpu_run_monitor.sv
// -----------------------------------------------------------------------------
// cpu_run_monitor
// Run-control and register-dump unit placed beside the cpu core. A start
// request enables the core for a programmable number of cycles (or until the
// core halts), then freezes it and streams registers FIRST_REG..LAST_REG out
// over a valid/ready channel.
//
// Ports:
//   clk          : single clock, rising edge
//   reset        : synchronous, active-high reset
//   start        : one-cycle run request, honoured in IDLE or DONE
//   max_cycles   : run length, sampled when start is accepted
//   halt_in      : core halt indication, ends the run early
//   cpu_run      : execution enable to the core
//   dbg          : register-file read port and dump channel (master side)
//   cycle_count  : cycles executed in the current or last run
//   done         : run and dump complete
// -----------------------------------------------------------------------------
module cpu_run_monitor
  import cpu_dbg_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 4,
  parameter int CYCLE_W   = DEF_CYCLE_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CYCLE_W-1:0]  max_cycles,
  input  logic                halt_in,
  output logic                cpu_run,
  cpu_run_monitor_if.master   dbg,
  output logic [CYCLE_W-1:0]  cycle_count,
  output logic                done
);

  // The read pointer carries one extra bit so it can step past LAST_REG even
  // when LAST_REG is the top register-file address.
  localparam int                PTR_W     = ADDR_W + 1;
  localparam logic [PTR_W-1:0]  PTR_FIRST = PTR_W'(FIRST_REG);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(LAST_REG);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(LAST_REG);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  run_state_e         state_q, state_d;

  logic [CYCLE_W-1:0] limit_q;
  logic [CYCLE_W-1:0] count_q;
  logic [PTR_W-1:0]   ptr_q;
  logic               valid_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [DATA_W-1:0]  data_q;

  // ---------------------------------------------------------------------------
  // Combinational control terms
  // ---------------------------------------------------------------------------
  logic               start_ok;
  logic [CYCLE_W-1:0] count_inc;
  logic               run_end;
  logic               load;
  logic               accept;
  logic               dump_end;

  always_comb begin
    start_ok  = start && start_allowed(state_q);
    count_inc = count_q + CYCLE_W'(1);

    // The cycle on which the run ends is itself counted, so the comparison
    // uses the incremented value. Halt and limit reached together give the
    // same single transition.
    run_end   = (count_inc == limit_q) || halt_in;

    // One-entry output register: refill when empty or being drained, while
    // registers remain in the range.
    load      = (state_q == ST_DUMP) && (!valid_q || dbg.dump_ready) &&
                (ptr_q <= PTR_LAST);
    accept    = valid_q && dbg.dump_ready;

    // Last word accepted: nothing further can load because the pointer has
    // already stepped past LAST_REG.
    dump_end  = (state_q == ST_DUMP) && accept && (idx_q == IDX_LAST) && !load;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d is given a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          // A zero-length run goes straight to the dump; the core never runs.
          state_d = (max_cycles == '0) ? ST_DUMP : ST_RUN;
        end
      end
      ST_RUN: begin
        if (run_end) begin
          state_d = ST_DUMP;
        end
      end
      ST_DUMP: begin
        if (dump_end) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: run limit, cycle counter, read pointer, dump output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      limit_q <= '0;
      count_q <= '0;
      ptr_q   <= PTR_FIRST;
      valid_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      if (start_ok) begin
        limit_q <= max_cycles;
        count_q <= '0;
        ptr_q   <= PTR_FIRST;
      end

      // The run always leaves RUN no later than the edge where the count
      // reaches the limit, so the counter cannot wrap.
      if (state_q == ST_RUN) begin
        count_q <= count_inc;
      end

      // Word contents only change on a load, and a load while valid requires
      // dump_ready, so the word stays stable while it is stalled.
      if (load) begin
        data_q  <= dbg.rf_rdata;
        idx_q   <= ptr_q[ADDR_W-1:0];
        valid_q <= 1'b1;
        ptr_q   <= ptr_q + PTR_W'(1);
      end else if (accept) begin
        valid_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cpu_run        = (state_q == ST_RUN);
  assign done           = (state_q == ST_DONE);
  assign cycle_count    = count_q;
  assign dbg.rf_raddr   = ptr_q[ADDR_W-1:0];
  assign dbg.dump_valid = valid_q;
  assign dbg.dump_idx   = idx_q;
  assign dbg.dump_data  = data_q;

endmodule : cpu_run_monitor

// File: tb/tb_cpu_run_monitor.sv
// -----------------------------------------------------------------------------
// tb_cpu_run_monitor
// Scoreboard bench for cpu_run_monitor. Stimulus pushes the expected dump
// words and the expected run summary into queues before each run; a monitor
// process compares every accepted transfer and every completed run.
// -----------------------------------------------------------------------------
module tb_cpu_run_monitor;
  import cpu_dbg_pkg::*;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 4;
  localparam int FIRST_R = 1;
  localparam int LAST_R  = 4;
  localparam int CYCLE_W = 16;

  typedef struct {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } word_t;

  typedef struct {
    int cycles;     // cpu_run high cycles and final cycle_count
    int vcycles;    // cycles with dump_valid high
  } run_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [CYCLE_W-1:0] max_cycles;
  logic               halt_in;
  logic               cpu_run;
  logic [CYCLE_W-1:0] cycle_count;
  logic               done;

  logic [DATA_W-1:0]  rf [16];

  cpu_run_monitor_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dbg ();

  assign dbg.rf_rdata = rf[dbg.rf_raddr];

  cpu_run_monitor #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .FIRST_REG(FIRST_R),
    .LAST_REG (LAST_R),
    .CYCLE_W  (CYCLE_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .max_cycles (max_cycles),
    .halt_in    (halt_in),
    .cpu_run    (cpu_run),
    .dbg        (dbg.master),
    .cycle_count(cycle_count),
    .done       (done)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  word_t exp_q[$];
  run_t  run_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // dump_ready driver: always ready, or a per-valid-cycle pattern
  // ---------------------------------------------------------------------------
  bit use_pat = 1'b0;
  bit pat [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int k;
    k = 0;
    dbg.dump_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (use_pat) begin
        if (dbg.dump_valid) begin
          dbg.dump_ready = pat[k];
          k = (k + 1) % 6;
        end else begin
          dbg.dump_ready = 1'b0;
        end
      end else begin
        dbg.dump_ready = 1'b1;
        k = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin
    int                run_cnt;
    int                vcnt;
    bit                hold_pend;
    bit                last_seen;
    bit                prev_done;
    logic [ADDR_W-1:0] held_idx;
    logic [DATA_W-1:0] held_data;
    word_t             w;
    run_t              r;
    run_cnt   = 0;
    vcnt      = 0;
    hold_pend = 1'b0;
    last_seen = 1'b0;
    prev_done = 1'b0;
    held_idx  = '0;
    held_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        run_cnt   = 0;
        vcnt      = 0;
        hold_pend = 1'b0;
        last_seen = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (last_seen) begin
          check("done_after_last", 32'(done), 32'd1);
          last_seen = 1'b0;
        end
        if (hold_pend) begin
          check("stall_valid", 32'(dbg.dump_valid), 32'd1);
          check("stall_idx",   32'(dbg.dump_idx),   32'(held_idx));
          check("stall_data",  32'(dbg.dump_data),  32'(held_data));
          hold_pend = 1'b0;
        end
        if (cpu_run)        run_cnt++;
        if (dbg.dump_valid) vcnt++;
        if (dbg.dump_valid && dbg.dump_ready) begin
          check("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check("dump_idx",  32'(dbg.dump_idx),  32'(w.idx));
            check("dump_data", 32'(dbg.dump_data), 32'(w.data));
            if (w.idx == ADDR_W'(LAST_R)) last_seen = 1'b1;
          end
        end else if (dbg.dump_valid) begin
          hold_pend = 1'b1;
          held_idx  = dbg.dump_idx;
          held_data = dbg.dump_data;
        end
        if (done && !prev_done) begin
          check("run_expected", 32'(run_q.size() != 0), 32'd1);
          if (run_q.size() != 0) begin
            r = run_q.pop_front();
            check("cpu_run_cycles", 32'(run_cnt),     32'(r.cycles));
            check("cycle_count",    32'(cycle_count), 32'(r.cycles));
            check("valid_cycles",   32'(vcnt),        32'(r.vcycles));
          end
          run_cnt = 0;
          vcnt    = 0;
        end
        prev_done = done;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic push_dump();
    for (int i = FIRST_R; i <= LAST_R; i++) begin
      exp_q.push_back('{idx: ADDR_W'(i), data: rf[i]});
    end
  endtask

  // Returns at #1 after the edge that accepts start (first RUN cycle).
  task automatic start_run(input int m);
    @(posedge clk);
    #1;
    start      = 1'b1;
    max_cycles = CYCLE_W'(m);
    @(posedge clk);
    #1;
    start      = 1'b0;
    max_cycles = '0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_timeout", 32'(seen), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cpu_run"},  32'(cpu_run),        32'd0);
    check({tag, "_valid"},    32'(dbg.dump_valid), 32'd0);
    check({tag, "_done"},     32'(done),           32'd0);
    check({tag, "_count"},    32'(cycle_count),    32'd0);
    check({tag, "_data"},     32'(dbg.dump_data),  32'd0);
    check({tag, "_idx"},      32'(dbg.dump_idx),   32'd0);
    check({tag, "_raddr"},    32'(dbg.rf_raddr),   32'(FIRST_R));
  endtask

  // Hard time bound in case the design stalls somewhere unexpected.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    max_cycles = '0;
    halt_in    = 1'b0;
    for (int i = 0; i < 16; i++) rf[i] = 16'h0F00 + DATA_W'(i);
    rf[1] = 16'd5;
    rf[2] = 16'd7;
    rf[3] = 16'd12;
    rf[4] = 16'd0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    reset = 1'b0;

    // 1: nine-cycle run, always ready: (1,5) (2,7) (3,12) (4,0).
    push_dump();
    run_q.push_back('{cycles: 9, vcycles: 4});
    start_run(9);
    check("t1_cpu_run_first", 32'(cpu_run), 32'd1);
    wait_done();

    // 2: limit 20, halt during the 6th RUN cycle.
    rf[1] = 16'hA5A5;
    rf[2] = 16'h0001;
    rf[3] = 16'hFFFF;
    rf[4] = 16'h1234;
    push_dump();
    run_q.push_back('{cycles: 6, vcycles: 4});
    start_run(20);
    repeat (5) @(posedge clk);
    #1;
    halt_in = 1'b1;
    @(posedge clk);
    #1;
    halt_in = 1'b0;
    check("t2_cpu_run_off", 32'(cpu_run), 32'd0);
    wait_done();

    // 3: ready pattern 0,0,1,0,1,1 per valid cycle -> 9 valid cycles.
    use_pat = 1'b1;
    push_dump();
    run_q.push_back('{cycles: 3, vcycles: 9});
    start_run(3);
    wait_done();
    use_pat = 1'b0;

    // 4: zero-length run.
    push_dump();
    run_q.push_back('{cycles: 0, vcycles: 4});
    start_run(0);
    check("t4_cpu_run_never", 32'(cpu_run), 32'd0);
    wait_done();

    // 5: reset after two transfers, then a clean 3-cycle run.
    push_dump();
    start_run(4);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("midrst");
    reset = 1'b0;
    exp_q.delete();
    push_dump();
    run_q.push_back('{cycles: 3, vcycles: 4});
    start_run(3);
    wait_done();

    // 6: start during RUN ignored; start in DONE restarts the count.
    push_dump();
    run_q.push_back('{cycles: 8, vcycles: 4});
    start_run(8);
    repeat (2) @(posedge clk);
    #1;
    start      = 1'b1;
    max_cycles = CYCLE_W'(2);
    @(posedge clk);
    #1;
    start      = 1'b0;
    max_cycles = '0;
    check("t6_ignore_run",   32'(cpu_run),     32'd1);
    check("t6_ignore_count", 32'(cycle_count), 32'd3);
    wait_done();

    push_dump();
    run_q.push_back('{cycles: 5, vcycles: 4});
    start_run(5);
    check("t6_restart_count", 32'(cycle_count), 32'd0);
    check("t6_restart_done",  32'(done),        32'd0);
    check("t6_restart_run",   32'(cpu_run),     32'd1);
    wait_done();

    check("runs_drained", 32'(run_q.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cpu_run_monitor
